lzw_byte_drain: RTL and testbench

Byte-drain stage directly downstream of the LZW output packing register. Pulls packed bytes from the packer with a single-cycle `read_data` strobe and buffers them in a small FIFO. Presents them to the byte sink over a valid/ready handshake. At end of stream it issues the packer's partial-byte flush and tags the final byte with `out_last`.

---
 rtl/lzw_pkg.sv | 18 +
 rtl/lzw_byte_fifo.sv | 59 +++++
 rtl/lzw_byte_drain.sv | 148 ++++++++++++++
 tb/tb_lzw_byte_drain.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lzw_pkg.sv
// Shared LZW definitions: byte width, drain FSM states and drain FIFO entry.
package lzw_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    RUN,
    FLUSH,
    LAST,
    DRAIN
  } drain_state_t;

  typedef struct packed {
    logic              last;
    logic [BYTE_W-1:0] data;
  } drain_entry_t;

endpackage

// File: rtl/lzw_byte_fifo.sv
// Small synchronous FIFO with full/empty flags derived from a registered occupancy count.
module lzw_byte_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  // Flags come only from the registered count, so a pop never frees a slot in the same cycle.
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Occupancy update; simultaneous push and pop leave it unchanged.
  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  // Storage array, data only, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/lzw_byte_drain.sv
// Byte drain behind the LZW packing register: pulls bytes with read_data, delays each
// through a hold register so the final one can be tagged last, and buffers them in a FIFO
// towards a valid/ready sink. Optional byte counter: define LZW_DRAIN_STATS_EN.
module lzw_byte_drain
  import lzw_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_dcnt,
  input  logic              tc_outreg,
  input  logic [BYTE_W-1:0] lzw_byte,
  input  logic              wr_busy,
  input  logic              eos,
  output logic              read_data,
  output logic [BYTE_W-1:0] out_byte,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready,
  output logic              done
`ifdef LZW_DRAIN_STATS_EN
  ,
  output logic [CNT_W-1:0]  byte_count
`endif
);

  drain_state_t      state_q, state_d;
  logic              hold_v_q, hold_v_d;
  logic [BYTE_W-1:0] hold_b_q, hold_b_d;
  logic              cap, flush_rd, room;
  logic              push, pop, fifo_full, fifo_empty;
  drain_entry_t      push_entry, head;

  // Capture needs somewhere for the current hold to go if one is pending.
  assign room = !hold_v_q || !fifo_full;

  // Next-state, capture strobe, hold update and FIFO push.
  always_comb begin
    state_d    = state_q;
    hold_v_d   = hold_v_q;
    hold_b_d   = hold_b_q;
    cap        = 1'b0;
    flush_rd   = 1'b0;
    push       = 1'b0;
    push_entry = '0;
    done       = 1'b0;
    case (state_q)
      RUN: begin
        cap = valid_dcnt && !wr_busy && room;
        if (eos) state_d = FLUSH;
      end
      FLUSH: begin
        if (!wr_busy) begin
          if (valid_dcnt) begin
            cap = room;
          end else if (!tc_outreg) begin
            // Partial-byte flush; waits for room so the pending hold is never dropped.
            if (room) begin
              flush_rd = 1'b1;
              state_d  = LAST;
            end
          end else if (hold_v_q) begin
            state_d = LAST;
          end else begin
            state_d = DRAIN;
          end
        end
      end
      LAST: begin
        if (!fifo_full) begin
          push       = 1'b1;
          push_entry = '{last: 1'b1, data: hold_b_q};
          hold_v_d   = 1'b0;
          state_d    = DRAIN;
        end
      end
      DRAIN: begin
        if (fifo_empty) begin
          done    = 1'b1;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
    read_data = cap || flush_rd;
    if (read_data) begin
      hold_b_d = lzw_byte;
      hold_v_d = 1'b1;
      if (hold_v_q) begin
        push       = 1'b1;
        push_entry = '{last: 1'b0, data: hold_b_q};
      end
    end
  end

  // FSM state and hold register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      hold_v_q <= 1'b0;
      hold_b_q <= '0;
    end else begin
      state_q  <= state_d;
      hold_v_q <= hold_v_d;
      hold_b_q <= hold_b_d;
    end
  end

  lzw_byte_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(drain_entry_t))
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_o      (head)
  );

  // Head is masked while empty so the outputs read zero out of reset.
  assign out_valid = !fifo_empty;
  assign out_byte  = fifo_empty ? '0 : head.data;
  assign out_last  = fifo_empty ? 1'b0 : head.last;
  assign pop       = out_valid && out_ready;

`ifdef LZW_DRAIN_STATS_EN
  logic [CNT_W-1:0] byte_count_q;

  // Saturating count of accepted bytes, cleared at end of each stream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_count_q <= '0;
    end else if (done) begin
      byte_count_q <= '0;
    end else if (pop && (byte_count_q != '1)) begin
      byte_count_q <= byte_count_q + CNT_W'(1);
    end
  end

  assign byte_count = byte_count_q;
`endif

endmodule

// File: tb/tb_lzw_byte_drain.sv
// Bench for lzw_byte_drain: behavioural packer model, scoreboard of expected bytes built
// from the written codes, directed stream scenarios.
module tb_lzw_byte_drain;

  localparam int DEPTH = 8;
  localparam int CNT_W = 24;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_dcnt, tc_outreg, wr_busy, read_data;
  logic [7:0]  lzw_byte, out_byte;
  logic        eos = 1'b0;
  logic        out_valid, out_last, done;
  logic        out_ready = 1'b1;
  logic        wr_en = 1'b0;
  logic [12:0] wr_code = '0;
`ifdef LZW_DRAIN_STATS_EN
  logic [CNT_W-1:0] byte_count;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int rd_cnt = 0, fl_cnt = 0, done_cnt = 0, pop_cnt = 0, acc = 0;
  logic [8:0]  exp_q[$];
  logic [12:0] cur_codes[$];

  always #5 clk = ~clk;

  lzw_byte_drain #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_dcnt (valid_dcnt),
    .tc_outreg  (tc_outreg),
    .lzw_byte   (lzw_byte),
    .wr_busy    (wr_busy),
    .eos        (eos),
    .read_data  (read_data),
    .out_byte   (out_byte),
    .out_valid  (out_valid),
    .out_last   (out_last),
    .out_ready  (out_ready),
    .done       (done)
`ifdef LZW_DRAIN_STATS_EN
    ,
    .byte_count (byte_count)
`endif
  );

  // Packer model: left-aligned bit buffer, 13-bit codes in, MSB-first bytes out.
  logic [127:0] pk_buf;
  int           pk_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pk_buf <= '0;
      pk_cnt <= 0;
    end else if (wr_en) begin
      pk_buf <= pk_buf | ({115'd0, wr_code} << (115 - pk_cnt));
      pk_cnt <= pk_cnt + 13;
    end else if (read_data) begin
      pk_buf <= pk_buf << 8;
      pk_cnt <= (pk_cnt >= 8) ? pk_cnt - 8 : 0;
    end
  end
  assign valid_dcnt = (pk_cnt >= 8);
  assign tc_outreg  = (pk_cnt == 0);
  assign lzw_byte   = pk_buf[127:120];
  assign wr_busy    = wr_en;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: strobe counters and scoreboard comparison of every accepted byte.
  always @(negedge clk) begin
    if (rst_n) begin
      if (read_data) rd_cnt++;
      if (read_data && !valid_dcnt) fl_cnt++;
      if (done) done_cnt++;
      if (out_valid && out_ready) begin
        logic [8:0] e;
`ifdef LZW_DRAIN_STATS_EN
        check("byte_count", byte_count, acc);
`endif
        check("q_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("out_byte", out_byte, e[7:0]);
          check("out_last", out_last, e[8]);
        end
        pop_cnt++;
        acc++;
      end
      if (done) acc = 0;
    end
  end

  // Expected bytes from the code list, built from an explicit bit sequence.
  task automatic push_expected();
    bit bq[$];
    int nbytes;
    logic [7:0] v;
    foreach (cur_codes[i])
      for (int b = 12; b >= 0; b--) bq.push_back(cur_codes[i][b]);
    nbytes = (bq.size() + 7) / 8;
    for (int i = 0; i < nbytes; i++) begin
      for (int j = 0; j < 8; j++) v[7-j] = (i*8 + j < bq.size()) ? bq[i*8 + j] : 1'b0;
      exp_q.push_back({(i == nbytes - 1), v});
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_code(input logic [12:0] c);
    wr_en = 1'b1;
    wr_code = c;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic make_codes(input int n);
    cur_codes.delete();
    for (int i = 0; i < n; i++) cur_codes.push_back(13'($urandom));
  endtask

  task automatic write_all();
    foreach (cur_codes[i]) begin
      write_code(cur_codes[i]);
      idle(1);
    end
  endtask

  task automatic send_eos();
    eos = 1'b1;
    @(posedge clk);
    #1;
    eos = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    int start;
    start = done_cnt;
    for (int k = 0; k < limit; k++) begin
      @(posedge clk);
      if (done_cnt != start) break;
    end
    idle(3);
    check(tag, done_cnt - start, 1);
  endtask

  initial begin
    int rd0, fl0, p0, d0, lat;

    // Reset state
    idle(3);
    check("rst_read_data", read_data, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_byte", out_byte, 0);
    check("rst_out_last", out_last, 0);
    check("rst_done", done, 0);
`ifdef LZW_DRAIN_STATS_EN
    check("rst_byte_count", byte_count, 0);
`endif
    rst_n = 1'b1;
    idle(2);

    // Three codes, partial final byte needs one flush strobe
    make_codes(3);
    push_expected();
    rd0 = rd_cnt; fl0 = fl_cnt; p0 = pop_cnt;
    write_all();
    send_eos();
    wait_done("t1_done", 200);
    check("t1_reads", rd_cnt - rd0, 5);
    check("t1_flush", fl_cnt - fl0, 1);
    check("t1_pops", pop_cnt - p0, 5);
    check("t1_q_empty", exp_q.size(), 0);

    // Eight codes, byte-aligned end, no flush strobe
    make_codes(8);
    push_expected();
    rd0 = rd_cnt; fl0 = fl_cnt; p0 = pop_cnt;
    write_all();
    send_eos();
    wait_done("t2_done", 200);
    check("t2_reads", rd_cnt - rd0, 13);
    check("t2_flush", fl_cnt - fl0, 0);
    check("t2_pops", pop_cnt - p0, 13);
    check("t2_q_empty", exp_q.size(), 0);

    // Backpressure: at most DEPTH+1 bytes absorbed
    out_ready = 1'b0;
    make_codes(8);
    push_expected();
    rd0 = rd_cnt; p0 = pop_cnt;
    write_all();
    idle(24);
    check("t3_absorbed", rd_cnt - rd0, DEPTH + 1);
    check("t3_no_pop", pop_cnt - p0, 0);
    check("t3_valid_held", out_valid, 1);
    out_ready = 1'b1;
    send_eos();
    wait_done("t3_done", 300);
    check("t3_pops", pop_cnt - p0, 13);
    check("t3_q_empty", exp_q.size(), 0);

    // wr_busy blocks capture in the cycle it coincides with valid_dcnt
    make_codes(2);
    push_expected();
    wr_en = 1'b1;
    wr_code = cur_codes[0];
    @(posedge clk);
    #1;
    wr_code = cur_codes[1];
    @(negedge clk);
    check("t4_vd_busy", valid_dcnt, 1);
    check("t4_rd_blocked", read_data, 0);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    @(negedge clk);
    check("t4_rd_resume", read_data, 1);
    @(posedge clk);
    #1;
    idle(6);
    send_eos();
    wait_done("t4_done", 200);
    check("t4_q_empty", exp_q.size(), 0);

    // Empty stream
    d0 = done_cnt; p0 = pop_cnt; rd0 = rd_cnt;
    eos = 1'b1;
    @(posedge clk);
    #1;
    eos = 1'b0;
    lat = 0;
    while (lat < 6 && done_cnt == d0) begin
      @(posedge clk);
      lat++;
    end
    check("t5_done_once", done_cnt - d0, 1);
    check("t5_done_lat_ok", lat <= 2, 1);
    check("t5_no_pop", pop_cnt - p0, 0);
    check("t5_no_read", rd_cnt - rd0, 0);
    idle(2);

    // Reset mid-stream with four bytes buffered
    out_ready = 1'b0;
    make_codes(3);
    write_all();
    idle(4);
    check("t6_pre_valid", out_valid, 1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    acc = 0;
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_byte", out_byte, 0);
    check("t6_rst_last", out_last, 0);
    check("t6_rst_read", read_data, 0);
    check("t6_rst_done", done, 0);
`ifdef LZW_DRAIN_STATS_EN
    check("t6_rst_count", byte_count, 0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    idle(2);
    make_codes(3);
    push_expected();
    p0 = pop_cnt;
    write_all();
    send_eos();
    wait_done("t6_done", 200);
    check("t6_pops", pop_cnt - p0, 5);
    check("t6_q_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
